// File: rtl/game_round_ctrl_pkg.sv
// Shared state encoding and helpers for the game round sequencer and its display consumers.
package game_round_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESTART = 2'd1,
        ST_PLAY     = 2'd2,
        ST_OVER     = 2'd3
    } state_e;

    // The second divider only runs in the two timed phases.
    function automatic logic timed_phase(state_e s);
        return (s == ST_PRESTART) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Button/sensor inputs and display/score outputs of the round sequencer.
// Optional pause signals exist only when GAME_PAUSE_EN is defined.
interface game_round_ctrl_if #(
    parameter int SCORE_W = 6
);
    import game_round_ctrl_pkg::*;

    logic               start_btn;
    logic               score_evt;
    logic [STATE_W-1:0] state;
    logic               game_active;
    logic               sec_tick;
    logic [1:0]         prestart_left;
    logic [5:0]         time_left;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               timer_expired;
`ifdef GAME_PAUSE_EN
    logic               pause_btn;
    logic               paused;

    modport master (
        output start_btn, score_evt, pause_btn,
        input  state, game_active, paused, sec_tick, prestart_left, time_left,
               score, high_score, timer_expired
    );
    modport slave (
        input  start_btn, score_evt, pause_btn,
        output state, game_active, paused, sec_tick, prestart_left, time_left,
               score, high_score, timer_expired
    );
`else
    modport master (
        output start_btn, score_evt,
        input  state, game_active, sec_tick, prestart_left, time_left,
               score, high_score, timer_expired
    );
    modport slave (
        input  start_btn, score_evt,
        output state, game_active, sec_tick, prestart_left, time_left,
               score, high_score, timer_expired
    );
`endif
endinterface

// File: rtl/game_round_ctrl_sec_tick_gen.sv
// Game-second divider: counts enabled cycles and pulses tick_o on the last cycle of each second.
module game_round_ctrl_sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over enable so every timed phase starts on a full second.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: start countdown, timed play window, score and session high score.
// Define GAME_PAUSE_EN to add the pause button and paused status.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 100_000_000,
    parameter int ROUND_SECS    = 30,
    parameter int PRESTART_SECS = 3,
    parameter int SCORE_W       = 6
) (
    input  logic             clkIn,
    input  logic             reset,
    game_round_ctrl_if.slave bus
);
    localparam logic [1:0]         PRE_INIT   = 2'(PRESTART_SECS);
    localparam logic [5:0]         ROUND_INIT = 6'(ROUND_SECS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_e             state_q;
    logic [1:0]         pre_q;
    logic [5:0]         time_q;
    logic [SCORE_W-1:0] score_q, score_d, high_q;
    logic               exp_q, start_q, evt_q;
    logic               start_rise, evt_rise, frozen, running, tick, enter_run, round_end;

`ifdef GAME_PAUSE_EN
    logic pause_q, paused_q, pause_rise;
    assign pause_rise = bus.pause_btn & ~pause_q;
    assign frozen     = paused_q;
    assign bus.paused = paused_q;
`else
    assign frozen = 1'b0;
`endif

    assign start_rise = bus.start_btn & ~start_q;
    assign evt_rise   = bus.score_evt & ~evt_q;
    assign running    = timed_phase(state_q) && !frozen;
    assign round_end  = tick && (state_q == ST_PLAY) && (time_q == 6'd1);
    assign enter_run  = (start_rise && (state_q == ST_IDLE || state_q == ST_OVER))
                     || (tick && (state_q == ST_PRESTART) && (pre_q == 2'd1));

    // Includes a point landing on the final tick so high score sees it.
    assign score_d = (state_q == ST_PLAY && !frozen && evt_rise && score_q != SCORE_MAX)
                   ? score_q + 1'b1 : score_q;

    game_round_ctrl_sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clkIn),
        .rst_i  (reset),
        .en_i   (running),
        .clr_i  (enter_run),
        .tick_o (tick)
    );

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            time_q   <= '0;
            score_q  <= '0;
            high_q   <= '0;
            exp_q    <= 1'b0;
            start_q  <= 1'b0;
            evt_q    <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
`endif
        end else begin
            start_q <= bus.start_btn;
            evt_q   <= bus.score_evt;
            exp_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_rise) begin
                        score_q <= '0;
                        if (PRESTART_SECS == 0) begin
                            state_q <= ST_PLAY;
                            time_q  <= ROUND_INIT;
                        end else begin
                            state_q <= ST_PRESTART;
                            pre_q   <= PRE_INIT;
                        end
                    end
                end
                ST_PRESTART: begin
                    if (tick) begin
                        pre_q <= pre_q - 2'd1;
                        if (pre_q == 2'd1) begin
                            state_q <= ST_PLAY;
                            time_q  <= ROUND_INIT;
                        end
                    end
                end
                ST_PLAY: begin
                    score_q <= score_d;
                    if (tick) time_q <= time_q - 6'd1;
                    if (round_end) begin
                        state_q <= ST_OVER;
                        exp_q   <= 1'b1;
                        if (score_d > high_q) high_q <= score_d;
                    end
                end
            endcase
`ifdef GAME_PAUSE_EN
            pause_q <= bus.pause_btn;
            if (state_q != ST_PLAY || round_end) paused_q <= 1'b0;
            else if (pause_rise)                 paused_q <= ~paused_q;
`endif
        end
    end

    assign bus.state         = state_q;
    assign bus.game_active   = (state_q == ST_PLAY) && !frozen;
    assign bus.sec_tick      = tick;
    assign bus.prestart_left = pre_q;
    assign bus.time_left     = time_q;
    assign bus.score         = score_q;
    assign bus.high_score    = high_q;
    assign bus.timer_expired = exp_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: two instances (SCORE_W 6 and 2) against a phase/second model.
module tb_game_round_ctrl;
    import game_round_ctrl_pkg::*;

    localparam int TICK_DIV = 10, ROUND_SECS = 5, PRESTART_SECS = 3;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef logic [25:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s, evt_s, pause_s;
    always #5 clk = ~clk;

    game_round_ctrl_if #(.SCORE_W(6)) bus_a ();
    game_round_ctrl_if #(.SCORE_W(2)) bus_b ();
    assign bus_a.start_btn = start_s;
    assign bus_a.score_evt = evt_s;
    assign bus_b.start_btn = start_s;
    assign bus_b.score_evt = evt_s;
`ifdef GAME_PAUSE_EN
    assign bus_a.pause_btn = pause_s;
    assign bus_b.pause_btn = pause_s;
`endif

    game_round_ctrl #(.TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS),
                      .PRESTART_SECS(PRESTART_SECS), .SCORE_W(6))
        dut_a (.clkIn(clk), .reset(rst), .bus(bus_a));
    game_round_ctrl #(.TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS),
                      .PRESTART_SECS(PRESTART_SECS), .SCORE_W(2))
        dut_b (.clkIn(clk), .reset(rst), .bus(bus_b));

    int n_chk = 0, n_pass = 0, n_fail = 0;
    bit mon_on = 1'b0;
    obs_t qa[$], qb[$];
    int te_dut[2] = '{0, 0};

    // Reference model: phase 0 idle, 1 countdown, 2 play, 3 over; sub = cycles into current second.
    int m_ph[2], m_sub[2], m_pre[2], m_tl[2], m_sc[2], m_hi[2], m_te[2];
    bit m_pz[2], m_ex[2];
    bit prv_s, prv_e, prv_p;
    int smax[2] = '{63, 3};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic obs_t pack(int i);
        bit tk;
        tk = (m_ph[i] == 1 || m_ph[i] == 2) && !m_pz[i] && (m_sub[i] == TICK_DIV - 1);
        return {2'(m_ph[i]), (m_ph[i] == 2) && !m_pz[i], m_pz[i], tk, 2'(m_pre[i]),
                6'(m_tl[i]), 6'(m_sc[i]), 6'(m_hi[i]), m_ex[i]};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit e, input bit p);
        bit sr, er, pr, run, tk, enter;
        sr = s && !prv_s;
        er = e && !prv_e;
        pr = PAUSE_EN && p && !prv_p;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_ph[i] = 0; m_sub[i] = 0; m_pre[i] = 0; m_tl[i] = 0;
                m_sc[i] = 0; m_hi[i] = 0; m_pz[i] = 0; m_ex[i] = 0;
            end else begin
                run = (m_ph[i] == 1 || m_ph[i] == 2) && !m_pz[i];
                tk = run && (m_sub[i] == TICK_DIV - 1);
                enter = 0;
                m_ex[i] = 0;
                case (m_ph[i])
                    1: if (tk) begin
                        m_pre[i]--;
                        if (m_pre[i] == 0) begin m_ph[i] = 2; m_tl[i] = ROUND_SECS; enter = 1; end
                    end
                    2: begin
                        if (er && !m_pz[i] && m_sc[i] < smax[i]) m_sc[i]++;
                        if (tk && m_tl[i] == 1) begin
                            m_tl[i] = 0; m_ph[i] = 3; m_ex[i] = 1; m_te[i]++; m_pz[i] = 0;
                            if (m_sc[i] > m_hi[i]) m_hi[i] = m_sc[i];
                        end else begin
                            if (tk) m_tl[i]--;
                            if (pr) m_pz[i] = !m_pz[i];
                        end
                    end
                    default: if (sr) begin
                        m_sc[i] = 0; enter = 1;
                        if (PRESTART_SECS > 0) begin m_ph[i] = 1; m_pre[i] = PRESTART_SECS; end
                        else begin m_ph[i] = 2; m_tl[i] = ROUND_SECS; end
                    end
                endcase
                if (enter) m_sub[i] = 0;
                else if (run) m_sub[i] = (m_sub[i] + 1) % TICK_DIV;
            end
        end
        prv_s = !r && s; prv_e = !r && e; prv_p = !r && p;
    endtask

    // One cycle: drive at the falling edge, predict the next rising edge, queue the prediction.
    task automatic cyc(input bit r, input bit s, input bit e, input bit p);
        @(negedge clk);
        rst = r; start_s = s; evt_s = e; pause_s = p;
        model_step(r, s, e, p);
        qa.push_back(pack(0));
        qb.push_back(pack(1));
    endtask

    function automatic obs_t obs_a();
        logic pz;
`ifdef GAME_PAUSE_EN
        pz = bus_a.paused;
`else
        pz = 1'b0;
`endif
        return {bus_a.state, bus_a.game_active, pz, bus_a.sec_tick, bus_a.prestart_left,
                bus_a.time_left, bus_a.score, bus_a.high_score, bus_a.timer_expired};
    endfunction

    function automatic obs_t obs_b();
        logic pz;
`ifdef GAME_PAUSE_EN
        pz = bus_b.paused;
`else
        pz = 1'b0;
`endif
        return {bus_b.state, bus_b.game_active, pz, bus_b.sec_tick, bus_b.prestart_left,
                bus_b.time_left, 4'b0, bus_b.score, 4'b0, bus_b.high_score, bus_b.timer_expired};
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_underflow got=empty expected=entry at %0t", $time);
            end else begin
                check("outs_a", 32'(obs_a()), 32'(qa.pop_front()));
                check("outs_b", 32'(obs_b()), 32'(qb.pop_front()));
                te_dut[0] += int'(bus_a.timer_expired);
                te_dut[1] += int'(bus_b.timer_expired);
            end
        end
    end

    task automatic start_round();
        int n;
        cyc(0, 1, 0, 0);
        n = 0;
        while (bus_a.state != ST_PLAY && n < 60) begin cyc(0, 0, 0, 0); n++; end
        check("reach_play_cycles", n, 31);
    endtask

    task automatic play_round(input int hits, output int n);
        n = 0;
        while (bus_a.state != ST_OVER && n < 200) begin
            cyc(0, 0, (n < 2 * hits) && (n % 2 == 1), 0);
            n++;
        end
    endtask

    initial begin
        int n, tl_hold;
        bit rs, rp;
        start_s = 0; evt_s = 0; pause_s = 0;
        m_te = '{0, 0};
        cyc(1, 0, 0, 0);
        mon_on = 1'b1;
        cyc(1, 0, 0, 0);
        check("rst_state", bus_a.state, ST_IDLE);
        check("rst_high", bus_a.high_score, 0);
        cyc(0, 0, 0, 0);

        // Countdown takes exactly 30 cycles.
        cyc(0, 1, 0, 0);
        repeat (30) cyc(0, 0, 0, 0);
        check("prestart_at29", bus_a.state, ST_PRESTART);
        check("prestart_left_1", bus_a.prestart_left, 1);
        cyc(0, 0, 0, 0);
        check("play_at30", bus_a.state, ST_PLAY);
        check("time_left_init", bus_a.time_left, 5);

        // Pulses, a held level and ignored start presses.
        repeat (3) begin cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); end
        repeat (20) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        check("score_4", bus_a.score, 4);
        check("score_sat_b", bus_b.score, 3);
        check("still_play", bus_a.state, ST_PLAY);

        n = 0;
        cyc(0, 0, 0, 0);
        while (!(m_ph[0] == 2 && m_tl[0] == 1 && m_sub[0] == TICK_DIV - 1) && n < 100) begin
            cyc(0, 0, 0, 0); n++;
        end
        check("final_tick_found", n < 100, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("over_state", bus_a.state, ST_OVER);
        check("expired_pulse", bus_a.timer_expired, 1);
        check("final_tick_point", bus_a.score, 5);
        check("high_5", bus_a.high_score, 5);
        check("high_b_3", bus_b.high_score, 3);
        cyc(0, 0, 0, 0);
        check("expired_1cycle", bus_a.timer_expired, 0);

        // Restart from OVER with a lower score, then a saturating round for the narrow instance.
        start_round();
        play_round(2, n);
        check("round_len_50", n, 50);
        check("score_2", bus_a.score, 2);
        check("high_kept_5", bus_a.high_score, 5);
        start_round();
        play_round(6, n);
        check("score_6", bus_a.score, 6);
        check("score_w2_sat", bus_b.score, 3);
        check("high_6", bus_a.high_score, 6);

        // Mid-round reset.
        start_round();
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        check("abort_state", bus_a.state, ST_IDLE);
        check("abort_high", bus_a.high_score, 0);
        check("abort_score", bus_a.score, 0);
        repeat (3) cyc(0, 0, 0, 0);

`ifdef GAME_PAUSE_EN
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        check("pause_idle_ignored", bus_a.paused, 0);
        start_round();
        n = 0; tl_hold = 0;
        while (bus_a.state != ST_OVER && n < 200) begin
            if (n == 6) tl_hold = int'(bus_a.time_left);
            if (n == 15) check("paused_flag", bus_a.paused, 1);
            if (n == 28) check("time_frozen", bus_a.time_left, tl_hold);
            cyc(0, 0, (n == 10 || n == 12 || n == 14 || n == 40), (n == 4 || n == 29));
            n++;
        end
        check("paused_round_len", n, 75);
        check("paused_hits_ignored", bus_a.score, 1);
`endif

        rs = 0; rp = 0;
        repeat (3000) begin
            if ($urandom_range(0, 29) == 0) rs = !rs;
            if ($urandom_range(0, 39) == 0) rp = !rp;
            cyc($urandom_range(0, 499) == 0, rs, $urandom_range(0, 2) == 0, rp);
        end
        cyc(0, 0, 0, 0);

        @(posedge clk);
        #2;
        mon_on = 1'b0;
        check("sb_drained", qa.size() + qb.size(), 0);
        check("expired_count_a", te_dut[0], m_te[0]);
        check("expired_count_b", te_dut[1], m_te[1]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
